// File: rtl/axi_wr_arbiter_if.sv
// Bundle of the arbiter's per-master write ports and its single slave-side write port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface axi_wr_arbiter_if #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
);
  localparam int unsigned AW_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13;
  localparam int unsigned B_W  = AXI_ID_WIDTH + 2;

  logic [NUM_MASTERS*AW_W-1:0]           s_axi_aw;
  logic [NUM_MASTERS-1:0]                s_axi_awvalid;
  logic [NUM_MASTERS-1:0]                s_axi_awready;
  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] s_axi_wdata;
  logic [NUM_MASTERS*AXI_STRB_WIDTH-1:0] s_axi_wstrb;
  logic [NUM_MASTERS-1:0]                s_axi_wlast;
  logic [NUM_MASTERS-1:0]                s_axi_wvalid;
  logic [NUM_MASTERS-1:0]                s_axi_wready;
  logic [B_W-1:0]                        s_axi_b;
  logic [NUM_MASTERS-1:0]                s_axi_bvalid;
  logic [NUM_MASTERS-1:0]                s_axi_bready;

  logic [AW_W-1:0]                       m_axi_aw;
  logic                                  m_axi_awvalid;
  logic                                  m_axi_awready;
  logic [AXI_DATA_WIDTH-1:0]             m_axi_wdata;
  logic [AXI_STRB_WIDTH-1:0]             m_axi_wstrb;
  logic                                  m_axi_wlast;
  logic                                  m_axi_wvalid;
  logic                                  m_axi_wready;
  logic [B_W-1:0]                        m_axi_b;
  logic                                  m_axi_bvalid;
  logic                                  m_axi_bready;

  modport slave (
    input  s_axi_aw, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_bready,
    output s_axi_awready, s_axi_wready, s_axi_b, s_axi_bvalid,
    output m_axi_aw, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_bready,
    input  m_axi_awready, m_axi_wready, m_axi_b, m_axi_bvalid
  );

  modport master (
    output s_axi_aw, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_bready,
    input  s_axi_awready, s_axi_wready, s_axi_b, s_axi_bvalid,
    input  m_axi_aw, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_bready,
    output m_axi_awready, m_axi_wready, m_axi_b, m_axi_bvalid
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write path between NUM_MASTERS requesters.
// One transaction in flight; grant held from AW handshake through B handshake.
module axi_wr_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input logic              clk,
  input logic              rst_n,
  axi_wr_arbiter_if.slave  bus
);
  localparam int unsigned AW_W  = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13;
  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] next_ptr;
  logic             any_req;
  int unsigned      idx;

  // Scan from the farthest candidate back to rr_ptr so the nearest requester wins.
  always_comb begin
    any_req = |bus.s_axi_awvalid;
    pick    = rr_ptr_q;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = (32'(rr_ptr_q) + NUM_MASTERS - 1 - k) % NUM_MASTERS;
      if (bus.s_axi_awvalid[IDX_W'(idx)]) begin
        pick = IDX_W'(idx);
      end
    end
    next_ptr = (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d = pick;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (bus.m_axi_awvalid && bus.m_axi_awready) state_d = StData;
      end
      StData: begin
        if (bus.m_axi_wvalid && bus.m_axi_wready && bus.m_axi_wlast) state_d = StResp;
      end
      StResp: begin
        if (bus.m_axi_bvalid && bus.m_axi_bready) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Payloads always follow the granted master; only valids/readies are gated by state.
  always_comb begin
    bus.m_axi_aw      = bus.s_axi_aw[32'(grant_q)*AW_W +: AW_W];
    bus.m_axi_wdata   = bus.s_axi_wdata[32'(grant_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    bus.m_axi_wstrb   = bus.s_axi_wstrb[32'(grant_q)*AXI_STRB_WIDTH +: AXI_STRB_WIDTH];
    bus.m_axi_wlast   = bus.s_axi_wlast[grant_q];
    bus.s_axi_b       = bus.m_axi_b;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wvalid  = 1'b0;
    bus.m_axi_bready  = 1'b0;
    bus.s_axi_awready = '0;
    bus.s_axi_wready  = '0;
    bus.s_axi_bvalid  = '0;
    unique case (state_q)
      StAddr: begin
        bus.m_axi_awvalid          = bus.s_axi_awvalid[grant_q];
        bus.s_axi_awready[grant_q] = bus.m_axi_awready;
      end
      StData: begin
        bus.m_axi_wvalid          = bus.s_axi_wvalid[grant_q];
        bus.s_axi_wready[grant_q] = bus.m_axi_wready;
      end
      StResp: begin
        bus.m_axi_bready          = bus.s_axi_bready[grant_q];
        bus.s_axi_bvalid[grant_q] = bus.m_axi_bvalid;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter with two masters; inputs change and outputs are
// sampled around the falling clock edge.
module tb_axi_wr_arbiter;
  localparam int unsigned NM  = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned IW  = 4;
  localparam int unsigned SW  = 4;
  localparam int unsigned AWW = IW + AW + 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  axi_wr_arbiter_if #(
    .NUM_MASTERS(NM), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
    .AXI_STRB_WIDTH(SW)
  ) bus ();

  axi_wr_arbiter #(
    .NUM_MASTERS(NM), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
    .AXI_STRB_WIDTH(SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [AWW-1:0] mk_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                           input logic [7:0] len, input logic [2:0] size,
                                           input logic [1:0] burst);
    return {id, addr, len, size, burst};
  endfunction

  task automatic idle_inputs();
    bus.s_axi_aw      = '0;
    bus.s_axi_awvalid = '0;
    bus.s_axi_wdata   = '0;
    bus.s_axi_wstrb   = '0;
    bus.s_axi_wlast   = '0;
    bus.s_axi_wvalid  = '0;
    bus.s_axi_bready  = '0;
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    bus.m_axi_b       = '0;
    bus.m_axi_bvalid  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single-beat transaction by master m, starting from IDLE; reports which ready/valid bits
  // were ever seen so callers can confirm that no other master was touched.
  task automatic drive_txn(input int m, input logic [DW-1:0] data, output logic [NM-1:0] aw_seen,
                           output logic [NM-1:0] w_seen, output logic [NM-1:0] b_seen);
    aw_seen = '0;
    w_seen  = '0;
    b_seen  = '0;
    @(negedge clk);
    bus.s_axi_awvalid[m]      = 1'b1;
    bus.s_axi_aw[m*AWW +: AWW] = mk_aw(IW'(m), 32'h200, 8'd0, 3'd2, 2'b01);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) begin
        bus.s_axi_awvalid[m]     = 1'b0;
        bus.s_axi_wvalid[m]      = 1'b1;
        bus.s_axi_wlast[m]       = 1'b1;
        bus.s_axi_wstrb[m*SW +: SW] = 4'hF;
        bus.s_axi_wdata[m*DW +: DW] = data;
      end else if (c == 3) begin
        bus.s_axi_wvalid[m] = 1'b0;
        bus.s_axi_wlast[m]  = 1'b0;
        bus.m_axi_bvalid    = 1'b1;
        bus.s_axi_bready[m] = 1'b1;
      end else if (c == 4) begin
        bus.m_axi_bvalid    = 1'b0;
        bus.s_axi_bready[m] = 1'b0;
      end
      #1;
      aw_seen = aw_seen | bus.s_axi_awready;
      w_seen  = w_seen | bus.s_axi_wready;
      b_seen  = b_seen | bus.s_axi_bvalid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.s_axi_awvalid = 2'b11;
    bus.s_axi_wvalid  = 2'b11;
    bus.s_axi_bready  = 2'b11;
    bus.m_axi_bvalid  = 1'b1;
    #1;
    checks++;
    if ({bus.m_axi_awvalid, bus.s_axi_awready, bus.m_axi_wvalid, bus.s_axi_wready,
         bus.s_axi_bvalid, bus.m_axi_bready} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {bus.m_axi_awvalid, bus.s_axi_awready,
               bus.m_axi_wvalid, bus.s_axi_wready, bus.s_axi_bvalid, bus.m_axi_bready});
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [AWW-1:0] exp_aw;
    exp_aw = mk_aw(4'h3, 32'h10, 8'd0, 3'd2, 2'b01);
    @(negedge clk);
    bus.s_axi_awvalid = 2'b01;
    bus.s_axi_aw[0 +: AWW] = exp_aw;
    bus.s_axi_wdata[DW +: DW] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.m_axi_awvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_bubble: awvalid %b want 0", bus.m_axi_awvalid);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.m_axi_awvalid, bus.s_axi_awready} !== 3'b1_01) begin
      errors++;
      $display("FAIL single_aw: got %b want 101", {bus.m_axi_awvalid, bus.s_axi_awready});
    end
    checks++;
    if (bus.m_axi_aw !== exp_aw) begin
      errors++;
      $display("FAIL single_aw_payload: got %h want %h", bus.m_axi_aw, exp_aw);
    end
    @(negedge clk);
    bus.s_axi_awvalid = 2'b00;
    bus.s_axi_wvalid[0] = 1'b1;
    bus.s_axi_wlast[0]  = 1'b1;
    bus.s_axi_wstrb[0 +: SW] = 4'hF;
    bus.s_axi_wdata[0 +: DW] = 32'hA5A5_0001;
    #1;
    checks++;
    if ({bus.m_axi_wvalid, bus.m_axi_wlast, bus.s_axi_wready, bus.m_axi_awvalid} !== 5'b1_1_01_0)
    begin
      errors++;
      $display("FAIL single_w: got %b want 11010", {bus.m_axi_wvalid, bus.m_axi_wlast,
               bus.s_axi_wready, bus.m_axi_awvalid});
    end
    checks++;
    if ({bus.m_axi_wdata, bus.m_axi_wstrb} !== {32'hA5A5_0001, 4'hF}) begin
      errors++;
      $display("FAIL single_wdata: got %h/%h want a5a50001/f", bus.m_axi_wdata, bus.m_axi_wstrb);
    end
    @(negedge clk);
    bus.s_axi_wvalid = 2'b00;
    bus.s_axi_wlast  = 2'b00;
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_b      = {4'h3, 2'b00};
    bus.s_axi_bready = 2'b11;
    #1;
    checks++;
    if ({bus.s_axi_bvalid, bus.m_axi_bready, bus.s_axi_b} !== {2'b01, 1'b1, 6'b0011_00}) begin
      errors++;
      $display("FAIL single_b: got %b/%b/%h want 01/1/0c", bus.s_axi_bvalid, bus.m_axi_bready,
               bus.s_axi_b);
    end
    @(negedge clk);
    bus.m_axi_bvalid = 1'b0;
    bus.s_axi_bready = 2'b00;
    #1;
    checks++;
    if ({bus.s_axi_bvalid, bus.s_axi_wready, bus.s_axi_awready} !== 6'b0) begin
      errors++;
      $display("FAIL single_idle: got %b want 0", {bus.s_axi_bvalid, bus.s_axi_wready,
               bus.s_axi_awready});
    end
  endtask

  task automatic test_back_to_back();
    int         exp_m;
    logic [1:0] oh;
    apply_reset();
    @(negedge clk);
    bus.s_axi_awvalid = 2'b11;
    bus.s_axi_aw[0 +: AWW]   = mk_aw(4'h0, 32'h1000, 8'd0, 3'd2, 2'b01);
    bus.s_axi_aw[AWW +: AWW] = mk_aw(4'h1, 32'h2000, 8'd0, 3'd2, 2'b01);
    for (int t = 0; t < 3; t++) begin
      exp_m = (t == 1) ? 1 : 0;
      oh    = 2'b01 << exp_m;
      @(negedge clk); #1;
      checks++;
      if (bus.s_axi_awready !== oh) begin
        errors++;
        $display("FAIL b2b_grant%0d: awready %b want %b", t, bus.s_axi_awready, oh);
      end
      @(negedge clk);
      bus.s_axi_awvalid[exp_m] = 1'b0;
      bus.s_axi_wvalid[exp_m]  = 1'b1;
      bus.s_axi_wlast[exp_m]   = 1'b1;
      bus.s_axi_wdata[exp_m*DW +: DW] = 32'hB000_0000 + DW'(t);
      #1;
      checks++;
      if ({bus.s_axi_wready, bus.m_axi_wdata} !== {oh, 32'hB000_0000 + DW'(t)}) begin
        errors++;
        $display("FAIL b2b_w%0d: wready %b data %h want %b/%h", t, bus.s_axi_wready,
                 bus.m_axi_wdata, oh, 32'hB000_0000 + DW'(t));
      end
      @(negedge clk);
      bus.s_axi_wvalid = 2'b00;
      bus.s_axi_wlast  = 2'b00;
      bus.m_axi_bvalid = 1'b1;
      bus.s_axi_bready = 2'b11;
      #1;
      checks++;
      if (bus.s_axi_bvalid !== oh) begin
        errors++;
        $display("FAIL b2b_b%0d: bvalid %b want %b", t, bus.s_axi_bvalid, oh);
      end
      @(negedge clk);
      bus.m_axi_bvalid = 1'b0;
      bus.s_axi_bready = 2'b00;
      if (t == 0) bus.s_axi_awvalid[0] = 1'b1;
    end
  endtask

  task automatic test_burst();
    int             beat_of_cycle [6];
    int             b;
    logic [AWW-1:0] exp_aw;
    logic [DW-1:0]  exp_d;
    beat_of_cycle = '{0, -1, 1, 2, -1, 3};
    exp_aw = mk_aw(4'h5, 32'h100, 8'd3, 3'd2, 2'b01);
    @(negedge clk);
    bus.s_axi_awvalid = 2'b10;
    bus.s_axi_aw[AWW +: AWW] = exp_aw;
    @(negedge clk); #1;
    checks++;
    if ({bus.s_axi_awready, bus.m_axi_aw} !== {2'b10, exp_aw}) begin
      errors++;
      $display("FAIL burst_aw: awready %b aw %h want 10/%h", bus.s_axi_awready, bus.m_axi_aw,
               exp_aw);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.s_axi_awvalid = 2'b00;
      b = beat_of_cycle[c];
      exp_d = 32'hC0DE_0000 + DW'(b);
      bus.s_axi_wvalid[1] = (b >= 0);
      bus.s_axi_wlast[1]  = (b == 3);
      bus.s_axi_wstrb[SW +: SW] = 4'hF;
      bus.s_axi_wdata[DW +: DW] = exp_d;
      #1;
      checks++;
      if (b >= 0) begin
        if ({bus.m_axi_wvalid, bus.m_axi_wlast, bus.s_axi_wready, bus.m_axi_wdata} !==
            {1'b1, (b == 3), 2'b10, exp_d}) begin
          errors++;
          $display("FAIL burst_beat%0d: v/l/rdy %b data %h want data %h", b,
                   {bus.m_axi_wvalid, bus.m_axi_wlast, bus.s_axi_wready}, bus.m_axi_wdata, exp_d);
        end
      end else if (bus.m_axi_wvalid !== 1'b0) begin
        errors++;
        $display("FAIL burst_gap%0d: wvalid %b want 0", c, bus.m_axi_wvalid);
      end
    end
    @(negedge clk);
    bus.s_axi_wvalid = 2'b00;
    bus.s_axi_wlast  = 2'b00;
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_b      = {4'h5, 2'b10};
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      #1;
      checks++;
      if ({bus.s_axi_bvalid, bus.m_axi_bready} !== 3'b10_0) begin
        errors++;
        $display("FAIL burst_bstall%0d: bvalid/bready %b want 100", s,
                 {bus.s_axi_bvalid, bus.m_axi_bready});
      end
    end
    @(negedge clk);
    bus.s_axi_bready[1] = 1'b1;
    #1;
    checks++;
    if ({bus.s_axi_bvalid, bus.m_axi_bready, bus.s_axi_b} !== {2'b10, 1'b1, 6'h16}) begin
      errors++;
      $display("FAIL burst_b: got %b/%b/%h want 10/1/16", bus.s_axi_bvalid, bus.m_axi_bready,
               bus.s_axi_b);
    end
    @(negedge clk);
    bus.m_axi_bvalid = 1'b0;
    bus.s_axi_bready = 2'b00;
    #1;
    checks++;
    if (bus.s_axi_bvalid !== 2'b00) begin
      errors++;
      $display("FAIL burst_done: bvalid %b want 00", bus.s_axi_bvalid);
    end
  endtask

  task automatic test_w_early();
    @(negedge clk);
    bus.s_axi_wvalid[0] = 1'b1;
    bus.s_axi_wlast[0]  = 1'b1;
    bus.s_axi_wstrb[0 +: SW] = 4'h3;
    bus.s_axi_wdata[0 +: DW] = 32'hE0E0_0001;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) begin
        bus.s_axi_awvalid[0] = 1'b1;
        bus.s_axi_aw[0 +: AWW] = mk_aw(4'h1, 32'h20, 8'd0, 3'd2, 2'b01);
      end
      #1;
      checks++;
      if ({bus.s_axi_wready, bus.m_axi_wvalid} !== 3'b0) begin
        errors++;
        $display("FAIL early_w%0d: wready/wvalid %b want 000", c,
                 {bus.s_axi_wready, bus.m_axi_wvalid});
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.s_axi_awready, bus.s_axi_wready} !== 4'b01_00) begin
      errors++;
      $display("FAIL early_addr: awready/wready %b want 0100",
               {bus.s_axi_awready, bus.s_axi_wready});
    end
    @(negedge clk);
    bus.s_axi_awvalid = 2'b00;
    #1;
    checks++;
    if ({bus.s_axi_wready, bus.m_axi_wvalid, bus.m_axi_wdata, bus.m_axi_wstrb} !==
        {2'b01, 1'b1, 32'hE0E0_0001, 4'h3}) begin
      errors++;
      $display("FAIL early_data: rdy %b v %b d %h s %h want 01/1/e0e00001/3", bus.s_axi_wready,
               bus.m_axi_wvalid, bus.m_axi_wdata, bus.m_axi_wstrb);
    end
    @(negedge clk);
    bus.s_axi_wvalid = 2'b00;
    bus.s_axi_wlast  = 2'b00;
    bus.m_axi_bvalid = 1'b1;
    bus.s_axi_bready[0] = 1'b1;
    #1;
    checks++;
    if (bus.s_axi_bvalid !== 2'b01) begin
      errors++;
      $display("FAIL early_b: bvalid %b want 01", bus.s_axi_bvalid);
    end
    @(negedge clk);
    bus.m_axi_bvalid = 1'b0;
    bus.s_axi_bready = 2'b00;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.s_axi_awvalid = 2'b01;
    bus.s_axi_aw[0 +: AWW] = mk_aw(4'h2, 32'h40, 8'd3, 3'd2, 2'b01);
    @(negedge clk);
    @(negedge clk);
    bus.s_axi_awvalid = 2'b00;
    bus.s_axi_wvalid[0] = 1'b1;
    bus.s_axi_wdata[0 +: DW] = 32'h0000_0001;
    #1;
    checks++;
    if (bus.s_axi_wready !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_beat1: wready %b want 01", bus.s_axi_wready);
    end
    @(negedge clk);
    bus.s_axi_wdata[0 +: DW] = 32'h0000_0002;
    bus.m_axi_bvalid = 1'b1;
    bus.s_axi_bready = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.m_axi_awvalid, bus.s_axi_awready, bus.m_axi_wvalid, bus.s_axi_wready,
         bus.s_axi_bvalid, bus.m_axi_bready} !== 9'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b want 0", {bus.m_axi_awvalid, bus.s_axi_awready,
               bus.m_axi_wvalid, bus.s_axi_wready, bus.s_axi_bvalid, bus.m_axi_bready});
    end
    idle_inputs();
    bus.s_axi_awvalid = 2'b11;
    bus.s_axi_aw[0 +: AWW]   = mk_aw(4'h0, 32'h80, 8'd0, 3'd2, 2'b01);
    bus.s_axi_aw[AWW +: AWW] = mk_aw(4'h1, 32'h90, 8'd0, 3'd2, 2'b01);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.s_axi_awready !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_tie: awready %b want 01", bus.s_axi_awready);
    end
    @(negedge clk);
    bus.s_axi_awvalid = 2'b00;
    bus.s_axi_wvalid[0] = 1'b1;
    bus.s_axi_wlast[0]  = 1'b1;
    @(negedge clk);
    bus.s_axi_wvalid = 2'b00;
    bus.s_axi_wlast  = 2'b00;
    bus.m_axi_bvalid = 1'b1;
    bus.s_axi_bready[0] = 1'b1;
    @(negedge clk);
    bus.m_axi_bvalid = 1'b0;
    bus.s_axi_bready = 2'b00;
  endtask

  task automatic test_rr_alone();
    logic [NM-1:0] aw_seen, w_seen, b_seen;
    drive_txn(1, 32'h1111_0001, aw_seen, w_seen, b_seen);
    checks++;
    if ({aw_seen, w_seen, b_seen} !== 6'b10_10_10) begin
      errors++;
      $display("FAIL alone_first: aw/w/b seen %b want 101010", {aw_seen, w_seen, b_seen});
    end
    drive_txn(1, 32'h1111_0002, aw_seen, w_seen, b_seen);
    checks++;
    if ({aw_seen, w_seen, b_seen} !== 6'b10_10_10) begin
      errors++;
      $display("FAIL alone_again: aw/w/b seen %b want 101010", {aw_seen, w_seen, b_seen});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_burst();
    test_w_early();
    test_reset_mid();
    test_rr_alone();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule
